shared_alu_scheduler: RTL and testbench

SHARED_ALU_SCHEDULER -- requirements
Module: shared_alu_scheduler

---
 rtl/shared_alu_scheduler.sv | 111 +++++++++++
 tb/tb_shared_alu_scheduler.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/shared_alu_scheduler.sv
// Multi-cycle scheduler for x/z. One adder/subtractor is reused across states
// to form d = a+b, e = a+c and f = a-b, and then the compare/select/shift
// network produces the results.
module shared_alu_scheduler #(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] c,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] x,
  output logic [DATAWIDTH-1:0] z
);

  typedef enum logic [2:0] {
    StIdle,
    StD,
    StE,
    StF,
    StCmp,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [DATAWIDTH-1:0] a_q, b_q, c_q;
  logic [DATAWIDTH-1:0] d_q, e_q, f_q;
  logic [DATAWIDTH-1:0] x_q, z_q, x_d, z_d;

  logic                 alu_sub;
  logic [DATAWIDTH-1:0] alu_b, alu_y;

  logic                 lt, eq;
  logic [DATAWIDTH-1:0] g, h;

  // Shared adder: operand select and add/sub mode follow the current state.
  // Subtraction is a + ~b + 1, so one carry chain serves both modes.
  always_comb begin
    alu_sub = (state_q == StF);
    alu_b   = (state_q == StE) ? c_q : b_q;
    alu_y   = a_q + (alu_b ^ {DATAWIDTH{alu_sub}}) + DATAWIDTH'(alu_sub);
  end

  // Compare, select and shift network evaluated from the held intermediates.
  always_comb begin
    lt  = (d_q < e_q);
    eq  = (d_q == e_q);
    g   = lt ? d_q : e_q;
    h   = eq ? g : f_q;
    x_d = lt ? (g << 1) : g;
    z_d = eq ? (h >> 1) : h;
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
    unique case (state_q)
      StIdle:  if (start) state_d = StD;
      StD:     state_d = StE;
      StE:     state_d = StF;
      StF:     state_d = StCmp;
      StCmp:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, operand, intermediate and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      e_q     <= '0;
      f_q     <= '0;
      x_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q <= a;
            b_q <= b;
            c_q <= c;
          end
        end
        StD:   d_q <= alu_y;
        StE:   e_q <= alu_y;
        StF:   f_q <= alu_y;
        StCmp: begin
          x_q <= x_d;
          z_q <= z_d;
        end
        default: ;
      endcase
    end
  end

  assign x = x_q;
  assign z = z_q;

endmodule

// File: tb/tb_shared_alu_scheduler.sv
// Directed bench for shared_alu_scheduler: known vectors, latency, start
// filtering while busy, back-to-back operation and mid-run reset.
module tb_shared_alu_scheduler;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b, c;
  logic         busy, done;
  logic [W-1:0] x, z;

  int unsigned  n_vec = 0;
  int unsigned  n_bad = 0;
  logic [W-1:0] px = '0;
  logic [W-1:0] pz = '0;

  always #5 clk = ~clk;

  shared_alu_scheduler #(.DATAWIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .c    (c),
    .busy (busy),
    .done (done),
    .x    (x),
    .z    (z)
  );

  // Advance one rising edge and settle before driving or sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full computation from a start pulse; operands are scrambled once
  // accepted, and x/z must hold the previous result until DONE.
  task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] ic, input logic [W-1:0] ex,
                        input logic [W-1:0] ez);
    a = ia; b = ib; c = ic; start = 1'b1;
    step();                                   // S_D
    start = 1'b0;
    chk({tag, " busy@S_D"}, W'(busy), 1);
    a = ~ia; b = ~ib; c = ~ic;
    step(); step(); step();                   // S_CMP
    chk({tag, " done@S_CMP"}, W'(done), 0);
    chk({tag, " x held"}, x, px);
    chk({tag, " z held"}, z, pz);
    step();                                   // DONE, 5th cycle after start edge
    chk({tag, " done"}, W'(done), 1);
    chk({tag, " x"}, x, ex);
    chk({tag, " z"}, z, ez);
    px = ex; pz = ez;
    step();                                   // IDLE
    chk({tag, " done drop"}, W'(done), 0);
    chk({tag, " busy drop"}, W'(busy), 0);
    chk({tag, " x after"}, x, ex);
  endtask

  initial begin
    // Reset, with start asserted simultaneously: reset must win.
    rst = 1'b1; start = 1'b1; a = 32'd5; b = 32'd3; c = 32'd1;
    step();
    chk("rst busy", W'(busy), 0);
    chk("rst done", W'(done), 0);
    chk("rst x", x, 0);
    chk("rst z", z, 0);
    step();
    chk("rst+start busy", W'(busy), 0);
    rst = 1'b0; start = 1'b0;
    step();
    chk("idle busy", W'(busy), 0);

    run_op("v1", 32'd5, 32'd3, 32'd1, 32'd6, 32'd2);
    run_op("v2", 32'd1, 32'd2, 32'd5, 32'd6, 32'hFFFF_FFFF);
    run_op("v3", 32'd4, 32'd4, 32'd4, 32'd8, 32'd4);
    run_op("v4", 32'hFFFF_FFFF, 32'd1, 32'd2, 32'd0, 32'hFFFF_FFFE);

    // Back-to-back with start held high: one IDLE cycle between runs.
    a = 32'd5; b = 32'd3; c = 32'd1; start = 1'b1;
    step();
    repeat (3) step();
    step();                                   // DONE
    chk("b2b first done", W'(done), 1);
    chk("b2b first x", x, 32'd6);
    chk("b2b first z", z, 32'd2);
    a = 32'd4; b = 32'd4; c = 32'd4;
    step();                                   // IDLE
    chk("b2b idle busy", W'(busy), 0);
    chk("b2b idle done", W'(done), 0);
    step();                                   // S_D
    chk("b2b restart busy", W'(busy), 1);
    start = 1'b0;
    repeat (3) step();
    step();                                   // DONE
    chk("b2b second done", W'(done), 1);
    chk("b2b second x", x, 32'd8);
    chk("b2b second z", z, 32'd4);
    step();

    // Start re-pulsed and a changed during S_E: single result from latched operands.
    a = 32'd5; b = 32'd3; c = 32'd1; start = 1'b1;
    step();                                   // S_D
    start = 1'b0;
    step();                                   // S_E
    start = 1'b1; a = 32'd99;
    step();                                   // S_F
    start = 1'b0;
    step();                                   // S_CMP
    chk("repulse early done", W'(done), 0);
    step();                                   // DONE
    chk("repulse done", W'(done), 1);
    chk("repulse x", x, 32'd6);
    chk("repulse z", z, 32'd2);
    start = 1'b1;                             // ignored in DONE
    step();                                   // IDLE
    chk("done-start busy", W'(busy), 0);
    chk("done-start done", W'(done), 0);
    start = 1'b0;
    step();
    chk("done-start stays idle", W'(busy), 0);
    chk("repulse no 2nd done", W'(done), 0);

    // Reset in S_F abandons the computation.
    a = 32'd1; b = 32'd2; c = 32'd5; start = 1'b1;
    step();                                   // S_D
    start = 1'b0;
    step(); step();                           // S_F
    chk("midrst busy pre", W'(busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst busy", W'(busy), 0);
    chk("midrst done", W'(done), 0);
    chk("midrst x", x, 0);
    chk("midrst z", z, 0);
    px = '0; pz = '0;
    step();
    chk("midrst no done 1", W'(done), 0);
    step();
    chk("midrst no done 2", W'(done), 0);
    run_op("post-rst", 32'd5, 32'd3, 32'd1, 32'd6, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
